// File: rtl/cmd_port_loader_pkg.sv
// Shared command codes, FSM state encoding and lane-width helper for cmd_port_loader.
// Build option CMD_PORT_READBACK_EN adds the read states.
package loader_pkg;

  localparam logic [7:0] CMD_NOP   = 8'd0;
  localparam logic [7:0] CMD_READ  = 8'd1;
  localparam logic [7:0] CMD_WRITE = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
`ifdef CMD_PORT_READBACK_EN
    RD_REQ,
    RD_WAIT,
`endif
    DONE,
    FLUSH
  } state_e;

  // Smallest w with 2**w >= word_bytes; word_bytes is a power of two.
  function automatic int lane_w(input int word_bytes);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < word_bytes) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cmd_port_loader_word_assembler.sv
// Byte-to-word write buffer: data, lane mask and word tag, plus fill/conflict/forward status.
// Build option CMD_PORT_READBACK_EN adds the read-forwarding outputs.
module word_assembler
  import loader_pkg::*;
#(
  parameter  int ADDR_W     = 8,
  parameter  int WORD_BYTES = 4,
  localparam int LANE_W     = lane_w(WORD_BYTES),
  localparam int WORD_W     = ADDR_W - LANE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    store,
  input  logic                    clear,
  input  logic [WORD_W-1:0]       word,
  input  logic [LANE_W-1:0]       lane,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] buf_data,
  output logic [WORD_BYTES-1:0]   buf_mask,
  output logic [WORD_W-1:0]       buf_tag,
  output logic                    fills,
  output logic                    conflict
`ifdef CMD_PORT_READBACK_EN
  ,
  output logic                    fwd_hit,
  output logic [7:0]              fwd_byte
`endif
);

  logic [8*WORD_BYTES-1:0] data_q, data_d, base_data;
  logic [WORD_BYTES-1:0]   mask_q, mask_d, base_mask, lane_bit;
  logic [WORD_W-1:0]       tag_q, tag_d;
  int                      lane_lsb;

  // Clear and store may coincide (flush followed by the new byte), so store builds on the cleared view.
  always_comb begin
    lane_bit       = '0;
    lane_bit[lane] = 1'b1;
    lane_lsb       = 8 * (WORD_BYTES - 1 - int'(lane));
    base_mask      = clear ? '0 : mask_q;
    base_data      = clear ? '0 : data_q;
    mask_d         = base_mask;
    data_d         = base_data;
    tag_d          = tag_q;
    fills          = ((base_mask | lane_bit) == '1);
    conflict       = (mask_q != '0) && (tag_q != word);
`ifdef CMD_PORT_READBACK_EN
    fwd_hit        = mask_q[lane] && (tag_q == word);
    fwd_byte       = data_q[lane_lsb +: 8];
`endif
    if (store) begin
      mask_d                 = base_mask | lane_bit;
      data_d[lane_lsb +: 8]  = byte_in;
      tag_d                  = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      tag_q  <= tag_d;
    end
  end

  assign buf_data = data_q;
  assign buf_mask = mask_q;
  assign buf_tag  = tag_q;

endmodule

// File: rtl/cmd_port_loader.sv
// Host command port: byte writes assembled into memory words, optional readback, core-run gating.
// Build option CMD_PORT_READBACK_EN enables READ; otherwise READ is rejected as illegal.
module cmd_port_loader
  import loader_pkg::*;
#(
  parameter  int ADDR_W     = 8,
  parameter  int WORD_BYTES = 4,
  localparam int LANE_W     = lane_w(WORD_BYTES),
  localparam int WORD_W     = ADDR_W - LANE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              cmd,
  input  logic                    cmd_valid,
  input  logic [ADDR_W-1:0]       address,
  input  logic [7:0]              data_in,
  input  logic                    start_signal,
  output logic                    cmd_done,
  output logic                    cmd_err,
  output logic [7:0]              data_out,
  output logic                    core_run,
  output logic                    mem_we,
  output logic [WORD_BYTES-1:0]   mem_be,
  output logic [WORD_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    mem_re,
  input  logic [8*WORD_BYTES-1:0] mem_rdata
);

  state_e                  state_q, state_d;
  logic                    err_q, err_d;
  logic                    core_run_q, core_run_d;
  logic                    start_prev_q, start_prev_d;
  logic                    start_pend_q, start_pend_d;
  logic                    start_flush_q, start_flush_d;
  logic [ADDR_W-1:0]       cmd_addr_q, cmd_addr_d;
  logic [7:0]              cmd_data_q, cmd_data_d;

  logic [ADDR_W-1:0]       q_addr;
  logic [WORD_W-1:0]       q_word;
  logic [LANE_W-1:0]       q_lane;
  logic [7:0]              q_byte;
  logic                    asm_store, asm_clear, fills, conflict, start_rise;
  logic [8*WORD_BYTES-1:0] buf_data;
  logic [WORD_BYTES-1:0]   buf_mask;
  logic [WORD_W-1:0]       buf_tag;

  // Decode uses the live host inputs in IDLE; later states replay the latched command.
  assign q_addr = (state_q == IDLE) ? address : cmd_addr_q;
  assign q_byte = (state_q == IDLE) ? data_in : cmd_data_q;
  assign q_word = q_addr[ADDR_W-1:LANE_W];
  assign q_lane = q_addr[LANE_W-1:0];

`ifdef CMD_PORT_READBACK_EN
  logic       fwd_hit;
  logic [7:0] fwd_byte, data_q, data_d, rd_byte;
  int         rd_lsb;

  always_comb begin
    rd_lsb  = 8 * (WORD_BYTES - 1 - int'(q_lane));
    rd_byte = mem_rdata[rd_lsb +: 8];
  end

  assign data_out = data_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign data_out     = '0;
`endif

  word_assembler #(
    .ADDR_W     (ADDR_W),
    .WORD_BYTES (WORD_BYTES)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .store    (asm_store),
    .clear    (asm_clear),
    .word     (q_word),
    .lane     (q_lane),
    .byte_in  (q_byte),
    .buf_data (buf_data),
    .buf_mask (buf_mask),
    .buf_tag  (buf_tag),
    .fills    (fills),
    .conflict (conflict)
`ifdef CMD_PORT_READBACK_EN
    ,
    .fwd_hit  (fwd_hit),
    .fwd_byte (fwd_byte)
`endif
  );

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    core_run_d    = core_run_q;
    start_rise    = start_signal & ~start_prev_q;
    start_prev_d  = start_signal;
    start_pend_d  = start_pend_q | start_rise;
    start_flush_d = start_flush_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    asm_store     = 1'b0;
    asm_clear     = 1'b0;
    mem_we        = 1'b0;
    mem_be        = '0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_re        = 1'b0;
`ifdef CMD_PORT_READBACK_EN
    data_d        = data_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_addr_d = address;
          cmd_data_d = data_in;
          err_d      = 1'b0;
          case (cmd)
            CMD_NOP: state_d = DONE;
            CMD_WRITE: begin
              if (core_run_q) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else if (conflict) begin
                start_flush_d = 1'b0;
                state_d       = FLUSH;
              end else begin
                asm_store = 1'b1;
                state_d   = fills ? COMMIT : DONE;
              end
            end
`ifdef CMD_PORT_READBACK_EN
            CMD_READ: state_d = RD_REQ;
`endif
            default: begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          endcase
        end else if (start_pend_q || start_rise) begin
          // A start request pushes out any partial word before the core is released.
          start_pend_d = 1'b0;
          if (buf_mask != '0) begin
            start_flush_d = 1'b1;
            state_d       = FLUSH;
          end else begin
            core_run_d = start_signal;
          end
        end
      end
      FLUSH: begin
        mem_we    = 1'b1;
        mem_be    = buf_mask;
        mem_addr  = buf_tag;
        mem_wdata = buf_data;
        asm_clear = 1'b1;
        if (start_flush_q) begin
          core_run_d = start_signal;
          state_d    = IDLE;
        end else begin
          asm_store = 1'b1;
          state_d   = fills ? COMMIT : DONE;
        end
      end
      COMMIT: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = buf_tag;
        mem_wdata = buf_data;
        asm_clear = 1'b1;
        state_d   = DONE;
      end
`ifdef CMD_PORT_READBACK_EN
      RD_REQ: begin
        mem_re   = 1'b1;
        mem_addr = q_word;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        data_d  = fwd_hit ? fwd_byte : rd_byte;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (!cmd_valid) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!start_signal) core_run_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      err_q         <= 1'b0;
      core_run_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      start_pend_q  <= 1'b0;
      start_flush_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
`ifdef CMD_PORT_READBACK_EN
      data_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      core_run_q    <= core_run_d;
      start_prev_q  <= start_prev_d;
      start_pend_q  <= start_pend_d;
      start_flush_q <= start_flush_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
`ifdef CMD_PORT_READBACK_EN
      data_q        <= data_d;
`endif
    end
  end

  assign cmd_done = (state_q == DONE);
  assign cmd_err  = err_q;
  assign core_run = core_run_q;

endmodule

// File: tb/tb_cmd_port_loader.sv
// Scoreboard bench for cmd_port_loader: stimulus queues expected memory strobes and
// command responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_cmd_port_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  address;
  logic [7:0]  data_in;
  logic        start_signal;
  logic        cmd_done;
  logic        cmd_err;
  logic [7:0]  data_out;
  logic        core_run;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rsp_t;

  wr_t        wr_q[$];
  rsp_t       rsp_q[$];
  logic [5:0] rd_q[$];

  int         checks = 0;
  int         errors = 0;
  logic       done_prev = 1'b0;
  logic [7:0] last_rd = 8'h00;
  logic       rd_err;
  logic [31:0] mem_model [0:63];

  always #5 clk = ~clk;

  cmd_port_loader #(
    .ADDR_W     (8),
    .WORD_BYTES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .address      (address),
    .data_in      (data_in),
    .start_signal (start_signal),
    .cmd_done     (cmd_done),
    .cmd_err      (cmd_err),
    .data_out     (data_out),
    .core_run     (core_run),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous-read memory model; mem_be bit i enables lane i, lane 0 being the MSB byte.
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) mem_model[mem_addr][31-8*l -: 8] = mem_wdata[31-8*l -: 8];
      end
    end
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented strobe or new completion is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t        w;
    rsp_t       r;
    logic [5:0] ra;
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_mem_we", 1, 0);
      end else begin
        w = wr_q.pop_front();
        checkOutput("mem_addr", mem_addr, w.addr);
        checkOutput("mem_be", mem_be, w.be);
        checkOutput("mem_wdata", mem_wdata, w.data);
      end
    end
    if (mem_re) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_mem_re", 1, 0);
      end else begin
        ra = rd_q.pop_front();
        checkOutput("mem_re_addr", mem_addr, ra);
      end
    end
    if (cmd_done && !done_prev) begin
      if (rsp_q.size() == 0) begin
        checkOutput("unexpected_cmd_done", 1, 0);
      end else begin
        r = rsp_q.pop_front();
        checkOutput("cmd_err", cmd_err, r.err);
        checkOutput("data_out", data_out, r.data);
      end
    end
    done_prev = cmd_done;
  end

  // Issue one command, check done latency (cycles after the sampling edge), optional hold, and release.
  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                               input logic exp_err, input logic [7:0] exp_data,
                               input int exp_lat, input int hold);
    int lat;
    rsp_q.push_back('{exp_err, exp_data});
    @(negedge clk);
    cmd       = c;
    address   = a;
    data_in   = d;
    cmd_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_done && lat < 20);
    checkOutput("done_latency", lat, exp_lat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("done_hold", cmd_done, 1);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_drop", cmd_done, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    cmd          = 8'd0;
    cmd_valid    = 1'b0;
    address      = 8'd0;
    data_in      = 8'd0;
    start_signal = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_done", cmd_done, 0);
    checkOutput("rst_cmd_err", cmd_err, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_core_run", core_run, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_re", mem_re, 0);
    rst_n = 1'b1;

    // Full word from four byte writes: only the last completes and commits.
    applyStimulus(8'd2, 8'd0, 8'h00, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd1, 8'h50, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd2, 8'h01, 1'b0, last_rd, 1, 0);
    wr_q.push_back('{6'd0, 4'b1111, 32'h00500113});
    applyStimulus(8'd2, 8'd3, 8'h13, 1'b0, last_rd, 2, 0);

    // Partial word 1 flushed by a write to word 2.
    applyStimulus(8'd2, 8'd4, 8'hAA, 1'b0, last_rd, 1, 0);
    wr_q.push_back('{6'd1, 4'b0001, 32'hAA000000});
    applyStimulus(8'd2, 8'd8, 8'h11, 1'b0, last_rd, 2, 0);
    applyStimulus(8'd2, 8'd9, 8'h5C, 1'b0, last_rd, 1, 0);

`ifdef CMD_PORT_READBACK_EN
    rd_q.push_back(6'd2);
    last_rd = 8'h5C;
    applyStimulus(8'd1, 8'd9, 8'h00, 1'b0, last_rd, 3, 0);
    rd_q.push_back(6'd0);
    last_rd = 8'h50;
    applyStimulus(8'd1, 8'd1, 8'h00, 1'b0, last_rd, 3, 0);
`else
    rd_err = 1'b1;
    applyStimulus(8'd1, 8'd9, 8'h00, rd_err, last_rd, 1, 0);
`endif

    // Held request executes once; completing byte commits word 2.
    applyStimulus(8'd2, 8'd10, 8'h22, 1'b0, last_rd, 1, 5);
    wr_q.push_back('{6'd2, 4'b1111, 32'h115C2233});
    applyStimulus(8'd2, 8'd11, 8'h33, 1'b0, last_rd, 2, 0);

    applyStimulus(8'd7, 8'd0, 8'h00, 1'b1, last_rd, 1, 0);
    applyStimulus(8'd0, 8'd0, 8'h00, 1'b0, last_rd, 1, 0);

    // Start with a partial word: flush first, then core_run; writes rejected while running.
    applyStimulus(8'd2, 8'd13, 8'h77, 1'b0, last_rd, 1, 0);
    wr_q.push_back('{6'd3, 4'b0010, 32'h00770000});
    @(negedge clk);
    start_signal = 1'b1;
    @(negedge clk);
    checkOutput("core_run_during_flush", core_run, 0);
    @(negedge clk);
    checkOutput("core_run_after_flush", core_run, 1);
    applyStimulus(8'd2, 8'd0, 8'h01, 1'b1, last_rd, 1, 0);
    @(negedge clk);
    start_signal = 1'b0;
    @(negedge clk);
    checkOutput("core_run_stop", core_run, 0);

    // Reset between decode and commit of a completing write.
    applyStimulus(8'd2, 8'd20, 8'h01, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd21, 8'h02, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd22, 8'h03, 1'b0, last_rd, 1, 0);
    @(negedge clk);
    cmd       = 8'd2;
    address   = 8'd23;
    data_in   = 8'h04;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem_we", mem_we, 0);
    checkOutput("abort_cmd_done", cmd_done, 0);
    checkOutput("abort_mem_wdata", mem_wdata, 0);
    checkOutput("abort_mem_be", mem_be, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    last_rd = 8'h00;

    // Cleared mask: a new word needs no flush and commits alone.
    applyStimulus(8'd2, 8'd24, 8'h99, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd25, 8'hAA, 1'b0, last_rd, 1, 0);
    applyStimulus(8'd2, 8'd26, 8'hBB, 1'b0, last_rd, 1, 0);
    wr_q.push_back('{6'd6, 4'b1111, 32'h99AABBCC});
    applyStimulus(8'd2, 8'd27, 8'hCC, 1'b0, last_rd, 2, 0);

    repeat (3) @(negedge clk);
    checkOutput("wr_queue_drained", wr_q.size(), 0);
    checkOutput("rd_queue_drained", rd_q.size(), 0);
    checkOutput("rsp_queue_drained", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
